serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and result width in bits; it SHALL be 2 or more.
REQ-002 Parameter BITS_PER_CYCLE, default 1, is the number of bits added per clock; it SHALL be at least 1 and SHALL divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-006 sub  input  1  mode: 0 = a+b+cin, 1 = a-b (cin ignored).
REQ-007 a  input  WIDTH  first operand; captured with start.
REQ-008 b  input  WIDTH  second operand; captured with start.
REQ-009 cin  input  1  carry-in for add mode; captured with start.
REQ-010 busy  output  1  high while an operation is in progress (RUN).
REQ-011 done  output  1  single-cycle pulse marking a valid new result.
REQ-012 sum  output  WIDTH  result, held until the next completion.
REQ-013 cout  output  1  carry-out; in sub mode, 1 = no borrow (a >= b unsigned).
REQ-014 ovf  output  1  two's-complement overflow of the completed operation.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after N = WIDTH/BITS_PER_CYCLE RUN cycles.
- DONE->RUN on start.
- DONE->IDLE otherwise.
REQ-016 On accepting start, the block SHALL capture the following and clear the step counter:
- a;
- b, inverted when sub=1;
- initial carry = (sub ? 1 : cin).
REQ-017 Each RUN cycle SHALL add the BITS_PER_CYCLE least-significant unprocessed bits, LSB first, through a ripple of full-adder cells, and SHALL register the carry for the next step.
REQ-018 Latency: with start sampled at edge k, done SHALL be high for exactly the cycle following edge k+N+1; for the default parameters, done rises at edge k+9.
REQ-019 busy SHALL be 1 exactly while in RUN and 0 in IDLE and DONE.
REQ-020 sum, cout and ovf SHALL update only on the RUN->DONE edge and SHALL otherwise hold their values, including throughout a following RUN.
REQ-021 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB of the final step.
REQ-022 The result SHALL be exact modulo 2^WIDTH, with no saturation.
REQ-023 start asserted during RUN SHALL be ignored and SHALL NOT disturb the operation in flight or the captured operands.
REQ-024 start asserted in DONE SHALL be accepted, giving back-to-back operations every N+1 cycles.
REQ-025 Changes on a, b, sub or cin after capture SHALL have no effect on the operation in flight.

Reset
REQ-026 rst_n low SHALL, asynchronously, force state IDLE, step counter 0, all internal operand/carry registers 0, and busy=0, done=0, sum=0, cout=0, ovf=0.
REQ-027 Reset asserted mid-operation SHALL abort it: no done pulse, no result update.
REQ-028 After rst_n rises, the block SHALL accept start on the first following rising edge.

Structure
REQ-029 A shared package serial_adder_pkg SHALL hold the state enumeration type and the state encodings.
REQ-030 A combinational one-bit full-adder sub-module, fa_cell (inputs x, y, ci; outputs s, co), SHALL be instantiated BITS_PER_CYCLE times in a ripple chain.
REQ-031 The step counter SHALL be sized as clog2(N)+1 bits.

Verification (WIDTH=8, BITS_PER_CYCLE=1 unless stated)
REQ-032 The bench SHALL cover each of the following directed scenarios:
- Add 8'h3C+8'h05, cin=0 -> sum=8'h41, cout=0, ovf=0; done at edge k+9; busy high for 8 cycles.
- Add 8'hFF+8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0; then 8'h7F+8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- Sub 8'h05-8'h07 -> sum=8'hFE, cout=0, ovf=0; then 8'h80-8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Operation 8'h10+8'h20 with start, a and b changed to 8'hFF during RUN, and start re-pulsed in the DONE cycle -> first result sum=8'h30; second operation begins without an IDLE gap.
- rst_n pulsed low 4 cycles after start -> busy=0, sum=0 immediately; no done pulse; a new operation then completes normally.
- BITS_PER_CYCLE=4: add 8'h99+8'h67, cin=0 -> sum=8'h00, cout=1, ovf=0; done at edge k+3.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state type and its encodings.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; chained to form the per-cycle ripple slice.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes BITS_PER_CYCLE bits per clock, LSB first,
// and presents sum/cout/ovf with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  state_t                    state_reg;
  state_t                    state_next;
  logic [CNT_W-1:0]          step_reg;
  logic [WIDTH-1:0]          a_reg;
  logic [WIDTH-1:0]          b_reg;
  logic                      carry_reg;
  logic                      load;
  logic                      last_step;
  logic [BITS_PER_CYCLE:0]   c;
  logic [BITS_PER_CYCLE-1:0] s_bits;
  logic [WIDTH-1:0]          a_shifted;

  assign c[0]      = carry_reg;
  assign last_step = (state_reg == RUN) && (step_reg == LAST_STEP);
  assign busy      = (state_reg == RUN);

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_ripple
      fa_cell u_fa (
        .x  (a_reg[gi]),
        .y  (b_reg[gi]),
        .ci (c[gi]),
        .s  (s_bits[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  // Result bits enter at the top of the a register as operand bits leave the
  // bottom, so after N steps a_reg itself holds the completed sum.
  generate
    if (N == 1) begin : g_single_step
      assign a_shifted = s_bits;
    end else begin : g_multi_step
      assign a_shifted = {s_bits, a_reg[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1; the captured carry supplies the +1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      step_reg  <= '0;
    end else if (load) begin
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub | cin;
      step_reg  <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_shifted;
      b_reg     <= b_reg >> BITS_PER_CYCLE;
      carry_reg <= c[BITS_PER_CYCLE];
      step_reg  <= step_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state_reg == DONE);
      if (last_step) begin
        sum  <= a_shifted;
        cout <= c[BITS_PER_CYCLE];
        ovf  <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, random ops against an
// arithmetic model, and hand-written multi-cycle sequences.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic       sub = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       ci;
    logic       sb;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Model from plain integer arithmetic: {sum, cout, ovf}.
  function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic ci, input logic sb);
    int ux, uy, sx, sy, ic, ur, sr;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ic = int'(ci);
    if (sb) begin
      ur = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end else begin
      ur = ux + uy + ic;
      sr = sx + sy + ic;
      co = (ur > 255);
    end
    ov = (sr > 127) || (sr < -128);
    return {ur[7:0], co, ov};
  endfunction

  task automatic run_op(input bit wide, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic sb,
                        output logic [7:0] rs, output logic rc, output logic ro,
                        output int lat, output int busy_n);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb;
    if (wide) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start4 = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    busy_n = wide ? int'(busy4) : int'(busy1);
    lat = -1;
    rs = 8'h00; rc = 1'b0; ro = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (wide ? done4 : done1) begin
        lat = e;
        rs = wide ? sum4 : sum1;
        rc = wide ? cout4 : cout1;
        ro = wide ? ovf4 : ovf1;
        break;
      end
      busy_n += wide ? int'(busy4) : int'(busy1);
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("done_pulse_width", 32'(wide ? done4 : done1), 32'd0);
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] rs, es;
    logic       rc, ro, ec, eo;
    int         lat, busy_n;
    logic [7:0] x, y;
    logic       ci, sb, wide, saw_done;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_sum", 32'(sum1), 32'd0);
    check("rst_cout", 32'(cout1), 32'd0);
    check("rst_ovf", 32'(ovf1), 32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, vecs[i].x, vecs[i].y, vecs[i].ci, vecs[i].sb, rs, rc, ro, lat, busy_n);
      $display("vec %0d: %h %s %h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               i, vecs[i].x, vecs[i].sb ? "-" : "+", vecs[i].y, vecs[i].ci, rs, rc, ro, lat);
      check("vec_sum", 32'(rs), 32'(vecs[i].e_sum));
      check("vec_cout", 32'(rc), 32'(vecs[i].e_cout));
      check("vec_ovf", 32'(ro), 32'(vecs[i].e_ovf));
      check("vec_latency", 32'(lat), 32'd9);
      if (i == 0) check("vec_busy_cycles", 32'(busy_n), 32'd8);
    end

    // Random operations on both widths of slice
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); sb = 1'($urandom);
      if (i % 6 == 0) x = 8'h80;
      if (i % 7 == 0) y = 8'hFF;
      wide = (i % 3 == 0);
      {es, ec, eo} = ref_op(x, y, ci, sb);
      run_op(wide, x, y, ci, sb, rs, rc, ro, lat, busy_n);
      $display("rnd %0d bpc=%0d: %h %s %h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               i, wide ? 4 : 1, x, sb ? "-" : "+", y, ci, rs, rc, ro, lat);
      check("rnd_sum", 32'(rs), 32'(es));
      check("rnd_cout", 32'(rc), 32'(ec));
      check("rnd_ovf", 32'(ro), 32'(eo));
      check("rnd_latency", 32'(lat), wide ? 32'd3 : 32'd9);
      check("rnd_busy_cycles", 32'(busy_n), wide ? 32'd2 : 32'd8);
    end

    // Four bits per cycle: directed case
    run_op(1'b1, 8'h99, 8'h67, 1'b0, 1'b0, rs, rc, ro, lat, busy_n);
    $display("bpc4: 99 + 67 -> sum=%h cout=%0d ovf=%0d lat=%0d", rs, rc, ro, lat);
    check("bpc4_sum", 32'(rs), 32'h00);
    check("bpc4_cout", 32'(rc), 32'd1);
    check("bpc4_ovf", 32'(ro), 32'd0);
    check("bpc4_latency", 32'(lat), 32'd3);

    // Operand changes and start during RUN ignored; restart in DONE
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; a = 8'hFF; b = 8'hFF;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) begin start1 = 1'b1; sub = 1'b1; end
      if (e == 4) start1 = 1'b0;
      if (e == 8) begin
        check("b2b_done_state_busy", 32'(busy1), 32'd0);
        check("b2b_done_early", 32'(done1), 32'd0);
        check("b2b_sum_at_done_state", 32'(sum1), 32'h30);
        a = 8'h01; b = 8'h02; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    $display("b2b first: sum=%h done=%0d busy=%0d", sum1, done1, busy1);
    check("b2b_first_done", 32'(done1), 32'd1);
    check("b2b_first_sum", 32'(sum1), 32'h30);
    check("b2b_no_idle_gap", 32'(busy1), 32'd1);
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 4) check("b2b_sum_held_in_run", 32'(sum1), 32'h30);
      if (done1) begin lat = e; break; end
    end
    $display("b2b second: sum=%h lat=%0d", sum1, lat);
    check("b2b_second_latency", 32'(lat), 32'd9);
    check("b2b_second_sum", 32'(sum1), 32'h03);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 8'h55; b = 8'h11; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("midreset: busy=%0d sum=%h done=%0d", busy1, sum1, done1);
    check("midreset_busy", 32'(busy1), 32'd0);
    check("midreset_sum", 32'(sum1), 32'd0);
    check("midreset_cout", 32'(cout1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      #1;
      if (done1) saw_done = 1'b1;
    end
    check("midreset_no_done", 32'(saw_done), 32'd0);
    check("midreset_sum_held", 32'(sum1), 32'd0);

    // Start accepted on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
    a = x; b = y; cin = ci; sub = 1'b0; start1 = 1'b1;
    {es, ec, eo} = ref_op(x, y, ci, 1'b0);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    check("post_reset_accept", 32'(busy1), 32'd1);
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (done1) begin lat = e; break; end
    end
    $display("post reset: %h + %h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             x, y, ci, sum1, cout1, ovf1, lat);
    check("post_reset_latency", 32'(lat), 32'd9);
    check("post_reset_sum", 32'(sum1), 32'(es));
    check("post_reset_cout", 32'(cout1), 32'(ec));
    check("post_reset_ovf", 32'(ovf1), 32'(eo));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
